counter_scheduler: RTL and testbench

//   Shares one WIDTH-bit counter register between NUM_REQ requesters.

---
 rtl/counter_scheduler_pkg.sv | 14 +
 rtl/counter_scheduler_rr_arbiter.sv | 36 +++
 rtl/counter_scheduler.sv | 162 ++++++++++++++++
 tb/tb_counter_scheduler.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/counter_scheduler_pkg.sv
// Shared encodings for the counter scheduler: op codes and FSM states.
package counter_scheduler_pkg;

    localparam logic [1:0] OP_INC   = 2'b00;
    localparam logic [1:0] OP_DEC   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/counter_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first eligible index at or after ptr, cyclically.
module rr_arbiter
    import counter_scheduler_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    int   rank;
    int   best_rank;
    int   best_idx;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        rank      = 0;
        best_rank = N;
        best_idx  = 0;
        // Rank = cyclic distance from ptr; smallest eligible rank wins.
        for (int i = 0; i < N; i++) begin
            rank = (i + N - int'(ptr)) % N;
            if (eligible[i] && rank < best_rank) begin
                best_rank = rank;
                best_idx  = i;
            end
        end
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = (best_rank < N) && (best_idx == i);
        end
    end

endmodule

// File: rtl/counter_scheduler.sv
// One shared WIDTH-bit counter driven by NUM_REQ requesters through a round-robin
// arbiter, with an optional bounded lock that lets one requester issue a burst.
module counter_scheduler
    import counter_scheduler_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 16,
    parameter int LOCK_MAX = 8
) (
    input  logic                     clock,
    input  logic                     reset_,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_lock,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]       ack,
    output logic [WIDTH-1:0]         counter,
    output logic                     locked,
    output logic                     wrap,
    output logic                     lock_timeout
);

    localparam int PW  = $clog2(NUM_REQ);
    localparam int LCW = $clog2(LOCK_MAX + 1);
    localparam logic [LCW-1:0] LOCK_ONE   = LCW'(1);
    localparam logic [LCW-1:0] LOCK_MAX_C = LCW'(LOCK_MAX);

    state_e               state_q, state_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [LCW-1:0]       lock_cnt_q, lock_cnt_d;
    logic [WIDTH-1:0]     counter_q, counter_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 wrap_q, wrap_d;
    logic                 timeout_q, timeout_d;

    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   owner_oh;
    logic [NUM_REQ-1:0]   apply_oh;
    logic [PW-1:0]        win_idx;
    logic [1:0]           op_sel;
    logic [WIDTH-1:0]     data_sel;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    // The ack mask keeps a non-locking requester from winning two cycles in a row.
    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
        .eligible (req_valid & ~ack_q),
        .ptr      (rr_ptr_q),
        .grant    (grant)
    );

    always_comb begin
        win_idx  = '0;
        owner_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) win_idx = PW'(i);
            owner_oh[i] = (owner_q == PW'(i));
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        timeout_d  = 1'b0;
        apply_oh   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    apply_oh = grant;
                    rr_ptr_d = next_ptr(win_idx);
                    if (|(req_lock & grant)) begin
                        state_d    = ST_LOCKED;
                        owner_d    = win_idx;
                        lock_cnt_d = LOCK_ONE;
                    end
                end
            end
            ST_LOCKED: begin
                if (|(req_valid & owner_oh)) apply_oh = owner_oh;
                if (|(req_lock & owner_oh)) begin
                    if (lock_cnt_q == LOCK_MAX_C) begin
                        state_d    = ST_IDLE;
                        lock_cnt_d = '0;
                        timeout_d  = 1'b1;
                        rr_ptr_d   = next_ptr(owner_q);
                    end else begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end
                end else begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Op and data are taken only from the requester applied this cycle.
    always_comb begin
        op_sel   = OP_INC;
        data_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (apply_oh[i]) begin
                op_sel   = req_op[2*i +: 2];
                data_sel = req_data[WIDTH*i +: WIDTH];
            end
        end
        counter_d = counter_q;
        wrap_d    = 1'b0;
        ack_d     = apply_oh;
        if (|apply_oh) begin
            unique case (op_sel)
                OP_INC: begin
                    counter_d = counter_q + 1'b1;
                    wrap_d    = &counter_q;
                end
                OP_DEC: begin
                    counter_d = counter_q - 1'b1;
                    wrap_d    = ~|counter_q;
                end
                OP_LOAD:  counter_d = data_sel;
                OP_CLEAR: counter_d = '0;
                default:  counter_d = counter_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous and beats any request.
    always_ff @(posedge clock) begin
        if (reset_) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            lock_cnt_q <= '0;
            counter_q  <= '0;
            ack_q      <= '0;
            wrap_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            counter_q  <= counter_d;
            ack_q      <= ack_d;
            wrap_q     <= wrap_d;
            timeout_q  <= timeout_d;
        end
    end

    assign ack          = ack_q;
    assign counter      = counter_q;
    assign locked       = (state_q == ST_LOCKED);
    assign wrap         = wrap_q;
    assign lock_timeout = timeout_q;

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed table-driven bench for counter_scheduler (NUM_REQ=4, WIDTH=16, LOCK_MAX=8).
module tb_counter_scheduler;

    logic        clock = 1'b0;
    logic        reset_;
    logic [3:0]  req_valid;
    logic [3:0]  req_lock;
    logic [7:0]  req_op;
    logic [63:0] req_data;
    logic [3:0]  ack;
    logic [15:0] counter;
    logic        locked;
    logic        wrap;
    logic        lock_timeout;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  lock;
        logic [7:0]  op;
        logic [63:0] data;
        logic [3:0]  e_ack;
        logic [15:0] e_cnt;
        logic        e_locked;
        logic        e_wrap;
        logic        e_to;
    } vec_t;

    vec_t vecs[$];

    counter_scheduler #(.NUM_REQ(4), .WIDTH(16), .LOCK_MAX(8)) dut (
        .clock        (clock),
        .reset_       (reset_),
        .req_valid    (req_valid),
        .req_lock     (req_lock),
        .req_op       (req_op),
        .req_data     (req_data),
        .ack          (ack),
        .counter      (counter),
        .locked       (locked),
        .wrap         (wrap),
        .lock_timeout (lock_timeout)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input logic rst, input logic [3:0] valid, input logic [3:0] lock,
                                input logic [7:0] op, input logic [63:0] data,
                                input logic [3:0] e_ack, input logic [15:0] e_cnt,
                                input logic e_locked, input logic e_wrap, input logic e_to);
        vec_t v;
        v.rst = rst; v.valid = valid; v.lock = lock; v.op = op; v.data = data;
        v.e_ack = e_ack; v.e_cnt = e_cnt; v.e_locked = e_locked; v.e_wrap = e_wrap; v.e_to = e_to;
        return v;
    endfunction

    // Drive one cycle of inputs, let the edge happen, then compare the registered outputs.
    task automatic apply_and_check(input string name, input vec_t v);
        logic [22:0] act;
        logic [22:0] exp;
        reset_    = v.rst;
        req_valid = v.valid;
        req_lock  = v.lock;
        req_op    = v.op;
        req_data  = v.data;
        @(posedge clock);
        #1;
        act = {ack, counter, locked, wrap, lock_timeout};
        exp = {v.e_ack, v.e_cnt, v.e_locked, v.e_wrap, v.e_to};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got ack=%b cnt=%h locked=%b wrap=%b to=%b, want ack=%b cnt=%h locked=%b wrap=%b to=%b",
                     name, ack, counter, locked, wrap, lock_timeout,
                     v.e_ack, v.e_cnt, v.e_locked, v.e_wrap, v.e_to);
        end
    endtask

    initial begin
        reset_ = 1'b1; req_valid = '0; req_lock = '0; req_op = '0; req_data = '0;

        // Reset, including reset beating a full set of requests, then 3 idle cycles.
        vecs.push_back(mk(1, 4'h0, 4'h0, 8'h00, 64'h0, 4'h0, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(1, 4'hF, 4'h0, 8'h00, 64'h0, 4'h0, 16'h0000, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 4'h0, 4'h0, 8'h00, 64'h0, 4'h0, 16'h0000, 0, 0, 0));

        // All four INC for 8 cycles: acks rotate 0,1,2,3,0,1,2,3.
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 4'hF, 4'h0, 8'h00, 64'h0, 4'(1 << (i % 4)), 16'(i + 1), 0, 0, 0));

        // req1 LOAD FFFF, then INC (masked one cycle) wraps to 0, then DEC wraps to FFFF.
        vecs.push_back(mk(0, 4'h2, 4'h0, 8'h08, 64'hAAAA_BBBB_FFFF_CCCC, 4'h2, 16'hFFFF, 0, 0, 0));
        vecs.push_back(mk(0, 4'h2, 4'h0, 8'h00, 64'h0, 4'h0, 16'hFFFF, 0, 0, 0));
        vecs.push_back(mk(0, 4'h2, 4'h0, 8'h00, 64'h0, 4'h2, 16'h0000, 0, 1, 0));
        vecs.push_back(mk(0, 4'h2, 4'h0, 8'h04, 64'h0, 4'h0, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 4'h2, 4'h0, 8'h04, 64'h0, 4'h2, 16'hFFFF, 0, 1, 0));
        vecs.push_back(mk(0, 4'h0, 4'h0, 8'h00, 64'h0, 4'h0, 16'hFFFF, 0, 0, 0));
        vecs.push_back(mk(0, 4'h1, 4'h0, 8'h03, 64'h0, 4'h1, 16'h0000, 0, 0, 0));

        // req2 lock+INC with req0 INC pending: entry ack, 8 locked acks, the last one force-released.
        vecs.push_back(mk(0, 4'h5, 4'h4, 8'h00, 64'h0, 4'h4, 16'h0001, 1, 0, 0));
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(0, 4'h5, 4'h4, 8'h00, 64'h0, 4'h4, 16'(i + 2), 1, 0, 0));
        vecs.push_back(mk(0, 4'h5, 4'h4, 8'h00, 64'h0, 4'h4, 16'h0009, 0, 0, 1));
        vecs.push_back(mk(0, 4'h5, 4'h4, 8'h00, 64'h0, 4'h1, 16'h000A, 0, 0, 0));
        vecs.push_back(mk(0, 4'h5, 4'h4, 8'h00, 64'h0, 4'h4, 16'h000B, 1, 0, 0));
        vecs.push_back(mk(0, 4'h5, 4'h4, 8'h00, 64'h0, 4'h4, 16'h000C, 1, 0, 0));
        vecs.push_back(mk(0, 4'h0, 4'h0, 8'h00, 64'h0, 4'h0, 16'h000C, 0, 0, 0));

        // req3 locks, then releases with LOAD 1234 while req0/req1 wait; req0 wins next.
        vecs.push_back(mk(0, 4'h8, 4'h8, 8'h00, 64'h0, 4'h8, 16'h000D, 1, 0, 0));
        vecs.push_back(mk(0, 4'hB, 4'h0, 8'h80, 64'h1234_7777_6666_5555, 4'h8, 16'h1234, 0, 0, 0));
        vecs.push_back(mk(0, 4'hB, 4'h0, 8'h00, 64'h0, 4'h1, 16'h1235, 0, 0, 0));

        // req1 locks, reset while locked with everyone requesting, then req0 wins first.
        vecs.push_back(mk(0, 4'h2, 4'h2, 8'h00, 64'h0, 4'h2, 16'h1236, 1, 0, 0));
        vecs.push_back(mk(1, 4'hF, 4'hF, 8'h00, 64'h0, 4'h0, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 4'hF, 4'h0, 8'h00, 64'h0, 4'h1, 16'h0001, 0, 0, 0));

        foreach (vecs[i]) apply_and_check($sformatf("vec%0d", i), vecs[i]);

        // Hand sequence: req3 holds the lock with no ops until the timer forces release.
        apply_and_check("idle_lock_entry",
                        mk(0, 4'h8, 4'h8, 8'h00, 64'h0, 4'h8, 16'h0002, 1, 0, 0));
        for (int i = 0; i < 7; i++)
            apply_and_check($sformatf("idle_lock_hold%0d", i),
                            mk(0, 4'h0, 4'h8, 8'h00, 64'h0, 4'h0, 16'h0002, 1, 0, 0));
        apply_and_check("idle_lock_timeout",
                        mk(0, 4'h0, 4'h8, 8'h00, 64'h0, 4'h0, 16'h0002, 0, 0, 1));
        apply_and_check("after_timeout_ptr",
                        mk(0, 4'hF, 4'h0, 8'h00, 64'h0, 4'h1, 16'h0003, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
